// File: rtl/simul_axi_wr_cmd_arbiter_pkg.sv
// Shared field widths for the simulated AXI write-address command path.
// These match the widths used by the wraddr channel model.
package simul_axi_wr_cmd_arbiter_pkg;

    localparam int unsigned LEN_W   = 4;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned CACHE_W = 4;
    localparam int unsigned PROT_W  = 3;

endpackage

// File: rtl/simul_axi_wr_order_fifo.sv
// Order FIFO of issued write commands ({requester index, awlen}).
// The head entry is read combinationally from the registered storage.
module simul_axi_wr_order_fifo #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/simul_axi_wr_cmd_arbiter.sv
// Round-robin arbiter sharing one AXI write-address command port between
// NUM_REQ requesters, plus issue-order tracking for the write-data side.
module simul_axi_wr_cmd_arbiter
    import simul_axi_wr_cmd_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned SEL_WIDTH     = 2,
    parameter int unsigned ID_WIDTH      = 12,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned ORDER_DEPTH   = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*ID_WIDTH-1:0]      awid_all,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] awaddr_all,
    input  logic [NUM_REQ*LEN_W-1:0]         awlen_all,
    input  logic [NUM_REQ*SIZE_W-1:0]        awsize_all,
    input  logic [NUM_REQ*BURST_W-1:0]       awburst_all,
    input  logic [NUM_REQ*CACHE_W-1:0]       awcache_all,
    input  logic [NUM_REQ*PROT_W-1:0]        awprot_all,
    output logic [NUM_REQ-1:0]               grant,
    output logic [ID_WIDTH-1:0]              awid_in,
    output logic [ADDRESS_WIDTH-1:0]         awaddr_in,
    output logic [LEN_W-1:0]                 awlen_in,
    output logic [SIZE_W-1:0]                awsize_in,
    output logic [BURST_W-1:0]               awburst_in,
    output logic [CACHE_W-1:0]               awcache_in,
    output logic [PROT_W-1:0]                awprot_in,
    output logic                             set_cmd,
    input  logic                             cmd_ready,
    input  logic                             wbeat,
    output logic [SEL_WIDTH-1:0]             wsel,
    output logic                             wsel_valid,
    output logic                             wlast,
    output logic                             order_full,
    output logic                             err
);

    localparam int unsigned ENT_W = SEL_WIDTH + LEN_W;

    logic [SEL_WIDTH-1:0]     last;
    logic [SEL_WIDTH-1:0]     winner;
    logic [SEL_WIDTH-1:0]     cand;
    logic                     found;
    logic                     issue;
    logic                     pop;
    logic                     fifo_empty;
    logic [ENT_W-1:0]         head;
    logic [LEN_W-1:0]         head_len;
    logic [LEN_W-1:0]         beat_cnt;
    logic [ID_WIDTH-1:0]      sel_id;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [LEN_W-1:0]         sel_len;
    logic [SIZE_W-1:0]        sel_size;
    logic [BURST_W-1:0]       sel_burst;
    logic [CACHE_W-1:0]       sel_cache;
    logic [PROT_W-1:0]        sel_prot;

    // Back-to-back issues are suppressed so cmd_ready reflects the previous load.
    assign issue = (|req) & cmd_ready & ~order_full & ~set_cmd;

    // First requesting index after the last winner, modulo NUM_REQ.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = SEL_WIDTH'((32'(last) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_id    = '0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        sel_cache = '0;
        sel_prot  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == SEL_WIDTH'(i)) begin
                sel_id    = awid_all[i*ID_WIDTH +: ID_WIDTH];
                sel_addr  = awaddr_all[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_len   = awlen_all[i*LEN_W +: LEN_W];
                sel_size  = awsize_all[i*SIZE_W +: SIZE_W];
                sel_burst = awburst_all[i*BURST_W +: BURST_W];
                sel_cache = awcache_all[i*CACHE_W +: CACHE_W];
                sel_prot  = awprot_all[i*PROT_W +: PROT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            set_cmd    <= 1'b0;
            grant      <= '0;
            last       <= SEL_WIDTH'(NUM_REQ - 1);
            awid_in    <= '0;
            awaddr_in  <= '0;
            awlen_in   <= '0;
            awsize_in  <= '0;
            awburst_in <= '0;
            awcache_in <= '0;
            awprot_in  <= '0;
        end else if (issue) begin
            set_cmd    <= 1'b1;
            grant      <= NUM_REQ'(1) << winner;
            last       <= winner;
            awid_in    <= sel_id;
            awaddr_in  <= sel_addr;
            awlen_in   <= sel_len;
            awsize_in  <= sel_size;
            awburst_in <= sel_burst;
            awcache_in <= sel_cache;
            awprot_in  <= sel_prot;
        end else begin
            set_cmd <= 1'b0;
            grant   <= '0;
        end
    end

    simul_axi_wr_order_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (issue),
        .pop   (pop),
        .din   ({winner, sel_len}),
        .dout  (head),
        .empty (fifo_empty),
        .full  (order_full)
    );

    assign wsel_valid = ~fifo_empty;
    assign wsel       = head[ENT_W-1:LEN_W];
    assign head_len   = head[LEN_W-1:0];
    assign wlast      = wsel_valid & (beat_cnt == head_len);
    assign pop        = wbeat & wlast;

    // Beat position within the head burst; a beat with nothing queued is an error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (wbeat & ~wsel_valid) begin
                err <= 1'b1;
            end
            if (wbeat & wsel_valid) begin
                beat_cnt <= wlast ? '0 : beat_cnt + LEN_W'(1);
            end
        end
    end

endmodule
